// File: rtl/impact_sram_ctrl_if.sv
// Host-side request/response bus of the IMPACT SRAM controller.
// The master issues single-word read/write requests and the slave
// (the controller) returns read data with a one-cycle strobe.
interface impact_sram_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    // Host side: drives requests, observes handshake and read results
    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err,
        input  busy
    );

    // Controller side: consumes requests, produces handshake and read results
    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err,
        output busy
    );
endinterface

// File: rtl/impact_sram_ctrl.sv
// IMPACT SRAM array controller.
// Sequences one access at a time through precharge, wordline access,
// sense (reads only) and recovery. Every array-side output is a flop that
// is loaded on the edge that enters the phase it belongs to, so the array
// never sees combinational glitches from the state decode.
module impact_sram_ctrl #(
    parameter int PRE_CYCLES = 2,
    parameter int WL_CYCLES  = 2
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n,
    impact_sram_ctrl_if.slave    bus,
    output logic [31:0]          wl,
    output logic                 pre_en,
    output logic                 bl_oe,
    output logic [31:0]          bl_out,
    output logic [31:0]          blb_out,
    input  logic [31:0]          bl_in,
    input  logic [31:0]          blb_in
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRECHARGE = 3'd1,
        ACCESS    = 3'd2,
        SENSE     = 3'd3,
        RECOVER   = 3'd4
    } state_t;

    // Terminal counts: the phase counter runs 0..N-1 inside a phase
    localparam logic [3:0] PRE_LAST = 4'(PRE_CYCLES - 1);
    localparam logic [3:0] WL_LAST  = 4'(WL_CYCLES - 1);

    state_t      state;
    logic [3:0]  phase_cnt;

    logic        we_q;
    logic [4:0]  addr_q;
    logic [31:0] wdata_q;

    logic        ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] wl_onehot;

    // Wordline decode of the captured row; loaded into wl on ACCESS entry
    assign wl_onehot = 32'd1 << addr_q;

    assign bus.req_ready = ready_q;
    assign bus.busy      = ~ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Access sequencer: state, phase counter, request capture and all registered outputs
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state       <= IDLE;
            phase_cnt   <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 5'd0;
            wdata_q     <= 32'd0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            wl          <= 32'd0;
            pre_en      <= 1'b0;
            bl_oe       <= 1'b0;
            bl_out      <= 32'd0;
            blb_out     <= 32'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        we_q      <= bus.req_we;
                        addr_q    <= bus.req_addr;
                        wdata_q   <= bus.req_wdata;
                        ready_q   <= 1'b0;
                        pre_en    <= 1'b1;
                        phase_cnt <= 4'd0;
                        state     <= PRECHARGE;
                    end
                end

                PRECHARGE: begin
                    if (phase_cnt == PRE_LAST) begin
                        phase_cnt <= 4'd0;
                        pre_en    <= 1'b0;
                        wl        <= wl_onehot;
                        if (we_q) begin
                            bl_oe   <= 1'b1;
                            bl_out  <= wdata_q;
                            blb_out <= ~wdata_q;
                        end
                        state <= ACCESS;
                    end else begin
                        phase_cnt <= phase_cnt + 4'd1;
                    end
                end

                ACCESS: begin
                    if (phase_cnt == WL_LAST) begin
                        phase_cnt <= 4'd0;
                        wl        <= 32'd0;
                        bl_oe     <= 1'b0;
                        bl_out    <= 32'd0;
                        blb_out   <= 32'd0;
                        state     <= we_q ? RECOVER : SENSE;
                    end else begin
                        phase_cnt <= phase_cnt + 4'd1;
                    end
                end

                SENSE: begin
                    // A cell drives exactly one of the pair low; equal rails mean a sense fault
                    rsp_rdata_q <= bl_in & ~blb_in;
                    rsp_err_q   <= |(bl_in ~^ blb_in);
                    rsp_valid_q <= 1'b1;
                    state       <= RECOVER;
                end

                RECOVER: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end

                default: begin
                    phase_cnt <= 4'd0;
                    wl        <= 32'd0;
                    pre_en    <= 1'b0;
                    bl_oe     <= 1'b0;
                    bl_out    <= 32'd0;
                    blb_out   <= 32'd0;
                    ready_q   <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_impact_sram_ctrl.sv
// Self-checking bench for impact_sram_ctrl.
// Two instances: the default 2/2 timing and a 15/15 long-timing copy.
// Expected behaviour comes from a cycle-timeline model of an access and
// a small array memory that supplies the sensed bitlines on reads.
module tb_impact_sram_ctrl;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic [31:0] bl_in;
    logic [31:0] blb_in;

    logic [31:0] wl_a, bl_out_a, blb_out_a;
    logic        pre_en_a, bl_oe_a;
    logic [31:0] wl_b, bl_out_b, blb_out_b;
    logic        pre_en_b, bl_oe_b;

    logic [31:0] o_wl, o_bl, o_blb, o_rdata;
    logic        o_pre, o_oe, o_ready, o_busy, o_rv, o_err;

    int checks;
    int errors;
    int pre_cnt, wl_cnt, overlap_cnt;

    logic [31:0] mem [32];
    logic [31:0] model_rdata [2];
    logic        model_err [2];

    impact_sram_ctrl_if bus_a ();
    impact_sram_ctrl_if bus_b ();

    assign bus_a.req_valid = req_valid & ~sel;
    assign bus_a.req_we    = req_we;
    assign bus_a.req_addr  = req_addr;
    assign bus_a.req_wdata = req_wdata;
    assign bus_b.req_valid = req_valid & sel;
    assign bus_b.req_we    = req_we;
    assign bus_b.req_addr  = req_addr;
    assign bus_b.req_wdata = req_wdata;

    impact_sram_ctrl #(.PRE_CYCLES(2), .WL_CYCLES(2)) dut_a (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .bus      (bus_a),
        .wl       (wl_a),
        .pre_en   (pre_en_a),
        .bl_oe    (bl_oe_a),
        .bl_out   (bl_out_a),
        .blb_out  (blb_out_a),
        .bl_in    (bl_in),
        .blb_in   (blb_in)
    );

    impact_sram_ctrl #(.PRE_CYCLES(15), .WL_CYCLES(15)) dut_b (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .bus      (bus_b),
        .wl       (wl_b),
        .pre_en   (pre_en_b),
        .bl_oe    (bl_oe_b),
        .bl_out   (bl_out_b),
        .blb_out  (blb_out_b),
        .bl_in    (bl_in),
        .blb_in   (blb_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe whichever instance the current test targets
    always_comb begin
        if (sel) begin
            o_wl = wl_b; o_bl = bl_out_b; o_blb = blb_out_b; o_pre = pre_en_b; o_oe = bl_oe_b;
            o_ready = bus_b.req_ready; o_busy = bus_b.busy; o_rv = bus_b.rsp_valid;
            o_rdata = bus_b.rsp_rdata; o_err = bus_b.rsp_err;
        end else begin
            o_wl = wl_a; o_bl = bl_out_a; o_blb = blb_out_a; o_pre = pre_en_a; o_oe = bl_oe_a;
            o_ready = bus_a.req_ready; o_busy = bus_a.busy; o_rv = bus_a.rsp_valid;
            o_rdata = bus_a.rsp_rdata; o_err = bus_a.rsp_err;
        end
    end

    // One full access starting at the current negedge (cycle 0 = accept cycle),
    // checking every cycle against the timeline P/W derived from the spec rules.
    task automatic run_txn(input string tag, input logic t_we, input logic [4:0] t_addr,
                           input logic [31:0] t_wdata, input logic [31:0] t_bl,
                           input logic [31:0] t_blb, input bit keep_valid, input bit noise);
        int p, w, last;
        logic [31:0] e_wl, e_bl, e_blb;
        logic e_pre, e_oe, e_ready, e_rv;
        p = sel ? 15 : 2;
        w = sel ? 15 : 2;
        last = t_we ? p + w + 2 : p + w + 3;
        pre_cnt = 0; wl_cnt = 0; overlap_cnt = 0;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept_ready got %b exp 1", tag, o_ready);
        end
        req_valid = 1'b1; req_we = t_we; req_addr = t_addr; req_wdata = t_wdata;
        bl_in = t_bl; blb_in = t_blb;
        if (t_we) mem[t_addr] = t_wdata;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            e_pre   = (k >= 1) && (k <= p);
            e_wl    = (k > p && k <= p + w) ? (32'd1 << t_addr) : 32'd0;
            e_oe    = t_we && (e_wl != 32'd0);
            e_bl    = e_oe ? t_wdata : 32'd0;
            e_blb   = e_oe ? ~t_wdata : 32'd0;
            e_ready = (k == last);
            e_rv    = !t_we && (k == p + w + 2);
            if (e_rv) begin
                model_rdata[sel] = t_bl & ~t_blb;
                model_err[sel]   = |(~(t_bl ^ t_blb));
            end
            if (o_pre === 1'b1) pre_cnt++;
            if (o_wl !== 32'd0) wl_cnt++;
            if (o_pre === 1'b1 && o_wl !== 32'd0) overlap_cnt++;
            checks += 9;
            if (o_pre !== e_pre) begin errors++; $display("FAIL %s c%0d pre_en got %b exp %b", tag, k, o_pre, e_pre); end
            if (o_wl !== e_wl) begin errors++; $display("FAIL %s c%0d wl got %h exp %h", tag, k, o_wl, e_wl); end
            if (o_oe !== e_oe) begin errors++; $display("FAIL %s c%0d bl_oe got %b exp %b", tag, k, o_oe, e_oe); end
            if (o_bl !== e_bl) begin errors++; $display("FAIL %s c%0d bl_out got %h exp %h", tag, k, o_bl, e_bl); end
            if (o_blb !== e_blb) begin errors++; $display("FAIL %s c%0d blb_out got %h exp %h", tag, k, o_blb, e_blb); end
            if (o_ready !== e_ready || o_busy !== ~e_ready) begin
                errors++; $display("FAIL %s c%0d ready/busy got %b/%b exp %b", tag, k, o_ready, o_busy, e_ready);
            end
            if (o_rv !== e_rv) begin errors++; $display("FAIL %s c%0d rsp_valid got %b exp %b", tag, k, o_rv, e_rv); end
            if (o_rdata !== model_rdata[sel]) begin
                errors++; $display("FAIL %s c%0d rsp_rdata got %h exp %h", tag, k, o_rdata, model_rdata[sel]);
            end
            if (o_err !== model_err[sel]) begin
                errors++; $display("FAIL %s c%0d rsp_err got %b exp %b", tag, k, o_err, model_err[sel]);
            end
            if (k < last) begin
                if (!keep_valid) req_valid = 1'b0;
                if (noise) begin
                    req_we = 1'($urandom); req_addr = 5'($urandom); req_wdata = $urandom;
                end
            end
        end
    endtask

    // Idle cycles: nothing must start and the array stays quiet
    task automatic idle_cycles(input string tag, input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (o_ready !== 1'b1 || o_rv !== 1'b0 || o_wl !== 32'd0 || o_pre !== 1'b0) begin
                errors++;
                $display("FAIL %s idle ready/rv/wl/pre got %b/%b/%h/%b exp 1/0/0/0", tag, o_ready, o_rv, o_wl, o_pre);
            end
        end
    endtask

    task automatic test_reset;
        sel = 1'b0; rst_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd3; req_wdata = 32'hDEADBEEF;
        bl_in = 32'd0; blb_in = 32'd0;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        model_rdata[0] = 32'd0; model_rdata[1] = 32'd0;
        model_err[0] = 1'b0; model_err[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks += 3;
        if (o_wl !== 32'd0 || o_pre !== 1'b0 || o_oe !== 1'b0 || o_bl !== 32'd0 || o_blb !== 32'd0) begin
            errors++; $display("FAIL reset array got wl=%h pre=%b oe=%b bl=%h blb=%h exp all 0", o_wl, o_pre, o_oe, o_bl, o_blb);
        end
        if (o_rv !== 1'b0 || o_rdata !== 32'd0 || o_err !== 1'b0) begin
            errors++; $display("FAIL reset rsp got rv=%b rdata=%h err=%b exp 0", o_rv, o_rdata, o_err);
        end
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++; $display("FAIL reset ready/busy got %b/%b exp 1/0", o_ready, o_busy);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        idle_cycles("reset_release", 3);
    endtask

    task automatic test_write;
        run_txn("write5", 1'b1, 5'd5, 32'hA5A50F0F, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_read;
        run_txn("read31", 1'b0, 5'd31, 32'd0, 32'h12345678, 32'hEDCBA987, 1'b0, 1'b0);
    endtask

    task automatic test_read_err;
        run_txn("read_err", 1'b0, 5'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        checks++;
        if (o_err !== 1'b1 || o_rdata !== 32'd0) begin
            errors++; $display("FAIL read_err flag got err=%b rdata=%h exp 1/0", o_err, o_rdata);
        end
        run_txn("write_keeps_err", 1'b1, 5'd9, 32'h0BADF00D, 32'd0, 32'd0, 1'b0, 1'b0);
        run_txn("read_clear", 1'b0, 5'd5, 32'd0, mem[5], ~mem[5], 1'b0, 1'b0);
        checks++;
        if (o_err !== 1'b0 || o_rdata !== 32'hA5A50F0F) begin
            errors++; $display("FAIL read_clear got err=%b rdata=%h exp 0/a5a50f0f", o_err, o_rdata);
        end
    endtask

    task automatic test_back_to_back;
        run_txn("b2b_0", 1'b1, 5'd12, 32'h11112222, 32'd0, 32'd0, 1'b1, 1'b1);
        run_txn("b2b_1", 1'b0, 5'd12, 32'd0, mem[12], ~mem[12], 1'b1, 1'b1);
        run_txn("b2b_2", 1'b1, 5'd0, 32'hCAFE0001, 32'd0, 32'd0, 1'b0, 1'b1);
        idle_cycles("b2b_idle", 2);
    endtask

    task automatic test_reset_mid;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd18; req_wdata = 32'd0;
        bl_in = 32'h0F0F0F0F; blb_in = 32'hF0F0F0F0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        checks++;
        if (o_wl !== (32'd1 << 18)) begin
            errors++; $display("FAIL rst_mid c3 wl got %h exp %h", o_wl, 32'd1 << 18);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (o_wl !== 32'd0 || o_rv !== 1'b0 || o_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid abort got wl=%h rv=%b ready=%b exp 0/0/1", o_wl, o_rv, o_ready);
        end
        rst_n = 1'b1;
        model_rdata[0] = 32'd0; model_err[0] = 1'b0;
        model_rdata[1] = 32'd0; model_err[1] = 1'b0;
        idle_cycles("rst_mid_quiet", 6);
        run_txn("rst_mid_write", 1'b1, 5'd21, 32'h600DCAFE, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        logic        r_we;
        logic [4:0]  r_addr;
        logic [31:0] r_data, r_fault;
        for (int n = 0; n < 24; n++) begin
            r_we   = 1'($urandom);
            r_addr = 5'($urandom);
            r_data = $urandom;
            r_fault = ($urandom_range(0, 3) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
            if (r_we)
                run_txn("rand_wr", 1'b1, r_addr, r_data, 32'd0, 32'd0, 1'b0, 1'b1);
            else
                run_txn("rand_rd", 1'b0, r_addr, 32'd0, mem[r_addr], ~mem[r_addr] ^ r_fault, 1'b0, 1'b1);
            if ($urandom_range(0, 1) == 1) idle_cycles("rand_gap", $urandom_range(1, 3));
        end
    endtask

    task automatic test_long;
        sel = 1'b1;
        idle_cycles("long_idle", 1);
        run_txn("long_wr", 1'b1, 5'd30, 32'h13579BDF, 32'd0, 32'd0, 1'b0, 1'b0);
        checks += 3;
        if (pre_cnt != 15) begin errors++; $display("FAIL long_wr pre_cycles got %0d exp 15", pre_cnt); end
        if (wl_cnt != 15) begin errors++; $display("FAIL long_wr wl_cycles got %0d exp 15", wl_cnt); end
        if (overlap_cnt != 0) begin errors++; $display("FAIL long_wr overlap got %0d exp 0", overlap_cnt); end
        run_txn("long_rd", 1'b0, 5'd30, 32'd0, mem[30], ~mem[30], 1'b0, 1'b0);
        checks += 3;
        if (pre_cnt != 15) begin errors++; $display("FAIL long_rd pre_cycles got %0d exp 15", pre_cnt); end
        if (wl_cnt != 15) begin errors++; $display("FAIL long_rd wl_cycles got %0d exp 15", wl_cnt); end
        if (overlap_cnt != 0) begin errors++; $display("FAIL long_rd overlap got %0d exp 0", overlap_cnt); end
        sel = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_write;
        test_read;
        test_read_err;
        test_back_to_back;
        test_reset_mid;
        test_random;
        test_long;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
